// File: rtl/bram_rmw_sequencer.sv
// bram_rmw_sequencer: read / add / write / read-back-verify engine that walks
// an inclusive, possibly wrapping address range on one BRAM port and reports
// pass/fail, a mismatch count and the first mismatching address.
module bram_rmw_sequencer #(
    parameter int P_DATA_WIDTH    = 16,
    parameter int P_ADDRESS_WIDTH = 10
) (
    input  logic                       I_CLK,
    input  logic                       I_RESET,
    input  logic                       I_START,
    input  logic [P_ADDRESS_WIDTH-1:0] I_BASE_ADDRESS,
    input  logic [P_ADDRESS_WIDTH-1:0] I_LAST_ADDRESS,
    input  logic [P_DATA_WIDTH-1:0]    I_ADDEND,
    input  logic [P_DATA_WIDTH-1:0]    I_BRAM_DATA,
    output logic [P_ADDRESS_WIDTH-1:0] O_BRAM_ADDRESS,
    output logic [P_DATA_WIDTH-1:0]    O_BRAM_DATA,
    output logic                       O_BRAM_WRITE_ENABLE,
    output logic                       O_BUSY,
    output logic                       O_DONE,
    output logic                       O_PASS,
    output logic [P_ADDRESS_WIDTH:0]   O_ERROR_COUNT,
    output logic [P_ADDRESS_WIDTH-1:0] O_FIRST_ERROR_ADDRESS
);

    localparam int AW = P_ADDRESS_WIDTH;
    localparam int DW = P_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_VREAD,
        S_VCHECK,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [AW-1:0]  last_q, last_d;
    logic [DW-1:0]  addend_q, addend_d;
    logic [DW-1:0]  expected_q, expected_d;
    logic [AW:0]    err_cnt_q, err_cnt_d;
    logic [AW-1:0]  first_err_q, first_err_d;
    logic           pass_q, pass_d;

    // State and datapath registers; reset returns everything to zero / S_IDLE
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            addend_q    <= '0;
            expected_q  <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            addend_q    <= addend_d;
            expected_q  <= expected_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

    // Next-state and register updates; five states per word, then one done cycle
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        addend_d    = addend_q;
        expected_d  = expected_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;

        unique case (state_q)
            S_IDLE: begin
                if (I_START) begin
                    addr_d      = I_BASE_ADDRESS;
                    last_d      = I_LAST_ADDRESS;
                    addend_d    = I_ADDEND;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Sum truncates to the word width; the carry is dropped on purpose
                expected_d = I_BRAM_DATA + addend_q;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_VREAD;
            end
            S_VREAD: begin
                state_d = S_VCHECK;
            end
            S_VCHECK: begin
                if (I_BRAM_DATA != expected_q) begin
                    // Count holds up to 2^AW, so a full-memory run cannot wrap it
                    err_cnt_d = err_cnt_q + (AW+1)'(1);
                    if (err_cnt_q == '0) begin
                        first_err_d = addr_q;
                    end
                end
                if (addr_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    // Natural AW-bit overflow gives the wrap through the top address
                    addr_d  = addr_q + AW'(1);
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                pass_d  = (err_cnt_q == '0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // BRAM port decode: address always tracks the address register, data only in S_WRITE
    always_comb begin
        O_BRAM_ADDRESS      = addr_q;
        O_BRAM_DATA         = '0;
        O_BRAM_WRITE_ENABLE = 1'b0;
        if (state_q == S_WRITE) begin
            O_BRAM_DATA         = expected_q;
            // Gate with reset so an abort during S_WRITE never commits the word
            O_BRAM_WRITE_ENABLE = ~I_RESET;
        end
    end

    // Status outputs
    always_comb begin
        O_BUSY                = (state_q == S_READ)  || (state_q == S_CAPTURE) ||
                                (state_q == S_WRITE) || (state_q == S_VREAD)   ||
                                (state_q == S_VCHECK);
        O_DONE                = (state_q == S_DONE);
        O_PASS                = pass_q;
        O_ERROR_COUNT         = err_cnt_q;
        O_FIRST_ERROR_ADDRESS = first_err_q;
    end

endmodule

// File: tb/tb_bram_rmw_sequencer.sv
// Bench for bram_rmw_sequencer: behavioural BRAM with optional write corruption,
// table-driven range runs plus hand-written mid-run start, reset-abort and full-memory cases.
module tb_bram_rmw_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_a, last_a;
    logic [15:0] addend;
    logic [15:0] rdata;
    logic [9:0]  baddr;
    logic [15:0] bwdata;
    logic        bwe, busy, done, pass;
    logic [10:0] err_cnt;
    logic [9:0]  ferr;

    bram_rmw_sequencer #(.P_DATA_WIDTH(16), .P_ADDRESS_WIDTH(10)) dut (
        .I_CLK(clk), .I_RESET(rst), .I_START(start),
        .I_BASE_ADDRESS(base_a), .I_LAST_ADDRESS(last_a), .I_ADDEND(addend),
        .I_BRAM_DATA(rdata),
        .O_BRAM_ADDRESS(baddr), .O_BRAM_DATA(bwdata), .O_BRAM_WRITE_ENABLE(bwe),
        .O_BUSY(busy), .O_DONE(done), .O_PASS(pass),
        .O_ERROR_COUNT(err_cnt), .O_FIRST_ERROR_ADDRESS(ferr)
    );

    always #5 clk = ~clk;

    // BRAM model: read-first, 1-cycle read latency, write log with cycle stamps
    logic [15:0] mem     [1024];
    logic [15:0] pre_mem [1024];
    bit          load_req = 1'b0;
    int          corrupt_addr = -1;
    bit          corrupt_all = 1'b0;
    int          cyc = 0;
    int          wr_n = 0;
    logic [9:0]  wr_addr [4096];
    int          wr_cyc  [4096];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_req) begin
            mem <= pre_mem;
        end else if (bwe) begin
            if (corrupt_all || (int'(baddr) == corrupt_addr)) mem[baddr] <= 16'hDEAD;
            else                                               mem[baddr] <= bwdata;
            if (wr_n < 4096) begin
                wr_addr[wr_n] <= baddr;
                wr_cyc[wr_n]  <= cyc;
            end
            wr_n <= wr_n + 1;
        end
        rdata <= mem[baddr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic preload();
        @(negedge clk); load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
    endtask

    task automatic fill_bg();
        for (int i = 0; i < 1024; i++) pre_mem[i] = 16'h5000 ^ 16'(i);
    endtask

    task automatic wait_done(input int limit, output int dc);
        dc = -1;
        for (int i = 0; i < limit && dc < 0; i++) begin
            if (done) dc = cyc;
            else @(negedge clk);
        end
        if (dc < 0) chk("done_timeout", 0, 1);
    endtask

    // Start a run, check the start-cycle status, wait for done, step to done+1
    task automatic run(input logic [9:0] b, input logic [9:0] l, input logic [15:0] ad,
                       input int limit, output int k, output int dc);
        @(negedge clk);
        base_a = b; last_a = l; addend = ad; start = 1'b1; k = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_at_start", busy, 1);
        chk("pass_cleared", pass, 0);
        chk("errcnt_cleared", err_cnt, 0);
        wait_done(limit, dc);
        @(negedge clk);
    endtask

    typedef struct {
        logic [9:0]       base, last;
        logic [15:0]      addend;
        int               n;
        logic [3:0][9:0]  addrs;
        logic [3:0][15:0] init, expv;
        int               corrupt;
        bit               pass;
        int               errs;
        logic [9:0]       ferr;
    } vec_t;

    function automatic vec_t mk(input logic [9:0] b, input logic [9:0] l, input logic [15:0] ad,
                                input int n, input logic [39:0] a, input logic [63:0] ini,
                                input logic [63:0] ex, input int cor, input bit p,
                                input int e, input logic [9:0] f);
        vec_t r;
        r.base = b; r.last = l; r.addend = ad; r.n = n; r.addrs = a;
        r.init = ini; r.expv = ex; r.corrupt = cor; r.pass = p; r.errs = e; r.ferr = f;
        return r;
    endfunction

    initial begin
        vec_t v [5];
        int   k, dc, w0, bad;
        logic [9:0] nb;

        v[0] = mk(10'h005, 10'h005, 16'h0001, 1, {30'h0, 10'h005},
                  {48'h0, 16'h1234}, {48'h0, 16'h1235}, -1, 1'b1, 0, 10'h000);
        v[1] = mk(10'h000, 10'h003, 16'h0001, 4, {10'h003, 10'h002, 10'h001, 10'h000},
                  {16'h8000, 16'hFFFF, 16'h0001, 16'h0000},
                  {16'h8001, 16'h0000, 16'h0002, 16'h0001}, -1, 1'b1, 0, 10'h000);
        v[2] = mk(10'h3FE, 10'h001, 16'h0100, 4, {10'h001, 10'h000, 10'h3FF, 10'h3FE},
                  {16'h0040, 16'h0030, 16'h0020, 16'h0010},
                  {16'h0140, 16'h0130, 16'h0120, 16'h0110}, -1, 1'b1, 0, 10'h000);
        v[3] = mk(10'h000, 10'h003, 16'h0001, 4, {10'h003, 10'h002, 10'h001, 10'h000},
                  {16'h8000, 16'hFFFF, 16'h0001, 16'h0000},
                  {16'h8001, 16'hDEAD, 16'h0002, 16'h0001}, 2, 1'b0, 1, 10'h002);
        v[4] = mk(10'h100, 10'h101, 16'hFFFF, 2, {20'h0, 10'h101, 10'h100},
                  {32'h0, 16'h0005, 16'h0000}, {32'h0, 16'h0004, 16'hFFFF}, -1, 1'b1, 0, 10'h000);

        rst = 1'b1; start = 1'b0; base_a = '0; last_a = '0; addend = '0;
        repeat (3) @(negedge clk);
        chk("rst_addr", baddr, 0);
        chk("rst_wdata", bwdata, 0);
        chk("rst_we", bwe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_ferr", ferr, 0);
        rst = 1'b0;

        // Table-driven range runs
        for (int t = 0; t < 5; t++) begin
            corrupt_addr = v[t].corrupt; corrupt_all = 1'b0;
            fill_bg();
            for (int j = 0; j < v[t].n; j++) pre_mem[v[t].addrs[j]] = v[t].init[j];
            preload();
            w0 = wr_n;
            run(v[t].base, v[t].last, v[t].addend, 100, k, dc);
            chk($sformatf("v%0d_done_cyc", t), dc, k + 1 + 5 * v[t].n);
            chk($sformatf("v%0d_first_wr_cyc", t), wr_cyc[w0], k + 3);
            chk($sformatf("v%0d_wr_count", t), wr_n - w0, v[t].n);
            chk($sformatf("v%0d_pass", t), pass, v[t].pass);
            chk($sformatf("v%0d_errcnt", t), err_cnt, v[t].errs);
            chk($sformatf("v%0d_ferr", t), ferr, v[t].ferr);
            chk($sformatf("v%0d_busy_after", t), busy, 0);
            for (int j = 0; j < v[t].n; j++) begin
                chk($sformatf("v%0d_wr_addr%0d", t, j), wr_addr[w0 + j], v[t].addrs[j]);
                chk($sformatf("v%0d_mem%0d", t, j), mem[v[t].addrs[j]], v[t].expv[j]);
            end
            nb = v[t].last + 10'd1;
            chk($sformatf("v%0d_neighbor", t), mem[nb], 16'h5000 ^ 16'(nb));
        end
        corrupt_addr = -1;

        // Mid-run start pulse and input changes are ignored
        fill_bg(); preload();
        w0 = wr_n;
        @(negedge clk);
        base_a = 10'h008; last_a = 10'h009; addend = 16'h0003; start = 1'b1; k = cyc;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; base_a = 10'h014; last_a = 10'h015; addend = 16'h0007;
        @(negedge clk); start = 1'b0;
        wait_done(100, dc);
        @(negedge clk);
        chk("mid_done_cyc", dc, k + 11);
        chk("mid_wr_count", wr_n - w0, 2);
        chk("mid_wr_addr0", wr_addr[w0], 10'h008);
        chk("mid_mem8", mem[8], 16'h500B);
        chk("mid_mem9", mem[9], 16'h500C);
        chk("mid_mem20", mem[20], 16'h5014);
        chk("mid_pass", pass, 1);

        // Reset during S_WRITE of word 2, then a fresh run
        fill_bg(); preload();
        w0 = wr_n;
        @(negedge clk);
        base_a = 10'h000; last_a = 10'h003; addend = 16'h0001; start = 1'b1; k = cyc;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 50 && cyc < k + 13; i++) @(negedge clk);
        chk("rstw_in_write", bwe, 1);
        chk("rstw_addr", baddr, 10'h002);
        rst = 1'b1;
        #1;
        chk("rstw_we_gated", bwe, 0);
        @(negedge clk);
        chk("rstw_addr0", baddr, 0);
        chk("rstw_busy0", busy, 0);
        chk("rstw_done0", done, 0);
        chk("rstw_pass0", pass, 0);
        chk("rstw_err0", err_cnt, 0);
        chk("rstw_ferr0", ferr, 0);
        chk("rstw_wdata0", bwdata, 0);
        rst = 1'b0;
        chk("rstw_wr_count", wr_n - w0, 2);
        chk("rstw_mem0", mem[0], 16'h5001);
        chk("rstw_mem1", mem[1], 16'h5002);
        chk("rstw_mem2", mem[2], 16'h5002);
        chk("rstw_mem3", mem[3], 16'h5003);
        run(10'h000, 10'h003, 16'h0001, 100, k, dc);
        chk("fresh_done_cyc", dc, k + 21);
        chk("fresh_pass", pass, 1);
        chk("fresh_mem0", mem[0], 16'h5002);
        chk("fresh_mem2", mem[2], 16'h5003);
        chk("fresh_mem3", mem[3], 16'h5004);
        repeat (5) @(negedge clk);
        chk("pass_holds", pass, 1);

        // Full memory with every write corrupted: count reaches 2^10 without wrapping
        for (int i = 0; i < 1024; i++) pre_mem[i] = 16'(i);
        preload();
        corrupt_all = 1'b1;
        w0 = wr_n;
        run(10'h000, 10'h3FF, 16'h0000, 6000, k, dc);
        corrupt_all = 1'b0;
        chk("full_done_cyc", dc, k + 1 + 5 * 1024);
        chk("full_wr_count", wr_n - w0, 1024);
        chk("full_errcnt", err_cnt, 11'h400);
        chk("full_ferr", ferr, 10'h000);
        chk("full_pass", pass, 0);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== 16'hDEAD) bad++;
        chk("full_mem_all_written", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_rmw_sequencer.md
# bram_rmw_sequencer

Read-modify-write-verify sequencer that drives one port of the `bram` block. On a start pulse it walks an inclusive address range. For each word it reads the value, adds a constant, writes the sum back, reads the word again and compares it to the expected sum. Pass/fail status, an error count and the first failing address are reported. It sits between the board top level (switch/button control, 7-segment status) and the BRAM, and is the bring-up engine for memory initialization and writeback checks.

## Interface
- P_DATA_WIDTH, 16, BRAM word width
- P_ADDRESS_WIDTH, 10, BRAM address width

- I_CLK  input  1  clock; all state changes on rising edge
- I_RESET  input  1  synchronous, active-high reset
- I_START  input  1  start request; sampled only in S_IDLE
- I_BASE_ADDRESS  input  P_ADDRESS_WIDTH  first address, latched at start
- I_LAST_ADDRESS  input  P_ADDRESS_WIDTH  last address (inclusive), latched at start
- I_ADDEND  input  P_DATA_WIDTH  value added to each word, latched at start
- I_BRAM_DATA  input  P_DATA_WIDTH  BRAM read data; valid the cycle after its address is presented
- O_BRAM_ADDRESS  output  P_ADDRESS_WIDTH  BRAM address
- O_BRAM_DATA  output  P_DATA_WIDTH  BRAM write data
- O_BRAM_WRITE_ENABLE  output  1  BRAM write enable
- O_BUSY  output  1  high from S_READ of the first word through S_VCHECK of the last word
- O_DONE  output  1  one-cycle completion pulse
- O_PASS  output  1  1 = last run had zero mismatches; valid from O_DONE until next start
- O_ERROR_COUNT  output  P_ADDRESS_WIDTH+1  mismatches in current/last run
- O_FIRST_ERROR_ADDRESS  output  P_ADDRESS_WIDTH  address of first mismatch; 0 if none

## Operation
- States: S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_VREAD, S_VCHECK, S_DONE.
- S_IDLE, I_START=1: latch base/last/addend. Load the address register with base. Clear error count, first-error address and O_PASS. Go to S_READ.
- S_READ: O_BRAM_ADDRESS = address register, WE=0. Go to S_CAPTURE.
- S_CAPTURE: register expected = I_BRAM_DATA + addend, modulo 2^P_DATA_WIDTH with the carry discarded. Go to S_WRITE.
- S_WRITE: present the address and expected value with WE=1. Go to S_VREAD.
- S_VREAD: present the address with WE=0. Go to S_VCHECK.
- S_VCHECK: compare I_BRAM_DATA with expected.
  - On mismatch, increment the error count. If this is the first error, record the address.
  - If address == last, go to S_DONE. Otherwise increment the address modulo 2^P_ADDRESS_WIDTH and go to S_READ.
- S_DONE: O_DONE=1; O_PASS = (error count == 0). Go to S_IDLE.
- BRAM outputs are combinational decodes of the state and registers. In S_IDLE, S_CAPTURE, S_VCHECK and S_DONE, the address holds its last value, data is 0 and WE=0.
- O_BRAM_WRITE_ENABLE is gated by ~I_RESET, so no write occurs in any cycle in which reset is asserted.
- Range rules:
  - last == base: exactly one word.
  - last < base: the range wraps through the top address to 0 and ends at last. For example, base=0x3FE, last=0x001 gives addresses 3FE, 3FF, 000, 001.
  - base=0, last=max: full memory, 2^P_ADDRESS_WIDTH words; the error count cannot overflow.
- I_START while not in S_IDLE is ignored; there is no queuing.
- Input changes after the latch have no effect on the current run.
- Reset, including mid-run: at the next edge go to S_IDLE; all status registers and outputs go to 0. Memory words already written stay modified.

## Timing
- Reset values: every output 0; state S_IDLE.
- I_START sampled high at edge k puts S_READ in cycle k+1.
- Each word takes exactly 5 cycles.
- N words puts O_DONE in cycle k+1+5N; S_IDLE follows in cycle k+2+5N, and a new start is accepted at the end of that cycle.
- BRAM read latency is 1 cycle. The address is presented in cycle t and the data is sampled in cycle t+1.
- The write in S_WRITE lands at the end of that cycle, before S_VREAD presents the address.
- O_ERROR_COUNT updates the cycle after the S_VCHECK mismatch. O_PASS updates the cycle after S_DONE and holds until the next start.

## Test plan
- Single word, base=last=0x005, mem[5]=0x1234, addend=0x0001:
  - write of 0x1235 to address 5 occurs in cycle k+3;
  - O_DONE occurs in cycle k+6;
  - O_PASS=1, O_ERROR_COUNT=0.
- Range 0x000..0x003 with init 0x0000, 0x0001, 0xFFFF, 0x8000 and addend 0x0001:
  - memory becomes 0x0001, 0x0002, 0x0000 (wrap), 0x8001;
  - O_DONE occurs in cycle k+21; pass.
- Wrap range base=0x3FE, last=0x001:
  - addresses visited in order 3FE, 3FF, 000, 001;
  - O_DONE occurs in cycle k+21.
- Bench BRAM model corrupts the write to address 0x002 (stores 0xDEAD), range 0..3:
  - O_ERROR_COUNT=1, O_FIRST_ERROR_ADDRESS=0x002, O_PASS=0;
  - the other three words are updated correctly.
- I_START pulsed mid-run, and inputs changed mid-run: no restart; the run completes on the latched range and addend.
- I_RESET asserted during S_WRITE of word 2:
  - no write occurs in that cycle;
  - next cycle has all outputs 0, S_IDLE;
  - words 0–1 are modified and words 2+ are untouched;
  - a fresh start then runs normally.
